// File: rtl/note_judge.sv
// Gameplay judging stage: walks a time-sorted note chart, judges arrow presses against the song timer and
// keeps score/combo. Define GHOST_PENALTY_EN to penalise stray presses with a GHOST judgement (code 3).
module note_judge #(
    parameter int ADDR_W      = 8,
    parameter int PERFECT_WIN = 2_500_000,
    parameter int GOOD_WIN    = 7_500_000,
    parameter int SCORE_W     = 16,
    parameter int PERFECT_PTS = 3,
    parameter int GOOD_PTS    = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               game_active,
    input  logic               paused,
    input  logic [63:0]        song_time,
    input  logic [3:0]         arrows,
    output logic [ADDR_W-1:0]  chart_addr,
    input  logic [34:0]        chart_data,
    output logic               judge_valid,
    output logic [1:0]         judge_result,
    output logic [1:0]         judge_lane,
    output logic [SCORE_W-1:0] score,
    output logic [9:0]         combo,
    output logic [9:0]         max_combo,
    output logic               chart_done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_WAIT_ROM = 3'd2;
    localparam logic [2:0] S_ARMED    = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [1:0] RES_MISS    = 2'd0;
    localparam logic [1:0] RES_GOOD    = 2'd1;
    localparam logic [1:0] RES_PERFECT = 2'd2;

    localparam logic [63:0]        PERFECT_WIN_64 = 64'(PERFECT_WIN);
    localparam logic [63:0]        GOOD_WIN_64    = 64'(GOOD_WIN);
    localparam logic [SCORE_W-1:0] PERFECT_PTS_W  = SCORE_W'(PERFECT_PTS);
    localparam logic [SCORE_W-1:0] GOOD_PTS_W     = SCORE_W'(GOOD_PTS);
    localparam logic [9:0]         COMBO_MAX      = 10'd1023;
    localparam logic [ADDR_W-1:0]  ADDR_LAST      = {ADDR_W{1'b1}};

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[SCORE_W]) begin
            return {SCORE_W{1'b1}};
        end else begin
            return sum[SCORE_W-1:0];
        end
    endfunction

`ifdef GHOST_PENALTY_EN
    localparam logic [1:0] RES_GHOST = 2'd3;

    function automatic logic [1:0] lowest_lane(input logic [3:0] a);
        logic [1:0] lane;
        if (a[0]) begin
            lane = 2'd0;
        end else if (a[1]) begin
            lane = 2'd1;
        end else if (a[2]) begin
            lane = 2'd2;
        end else begin
            lane = 2'd3;
        end
        return lane;
    endfunction

    logic ghost_s;
`endif

    logic [2:0]         state_r;
    logic               game_active_d_r;
    logic [31:0]        note_time_r;
    logic [1:0]         note_lane_r;
    logic [63:0]        note_time64_s;
    logic [63:0]        dist_s;
    logic               press_s;
    logic               perfect_s;
    logic               good_s;
    logic               miss_s;
    logic               judged_s;
    logic [1:0]         result_s;
    logic [9:0]         combo_inc_s;
    logic [9:0]         max_next_s;
    logic [SCORE_W-1:0] score_inc_s;

    // Judgement of the armed note for this cycle; distance is done in 64 bits so late times never wrap.
    always_comb begin
        note_time64_s = {32'd0, note_time_r};
        if (song_time >= note_time64_s) begin
            dist_s = song_time - note_time64_s;
        end else begin
            dist_s = note_time64_s - song_time;
        end
        press_s   = arrows[note_lane_r];
        perfect_s = press_s && (dist_s <= PERFECT_WIN_64);
        good_s    = press_s && !perfect_s && (dist_s <= GOOD_WIN_64);
        miss_s    = !perfect_s && !good_s && (song_time > (note_time64_s + GOOD_WIN_64));
        judged_s  = perfect_s || good_s || miss_s;
        combo_inc_s = (combo == COMBO_MAX) ? COMBO_MAX : (combo + 10'd1);
        if (perfect_s) begin
            result_s    = RES_PERFECT;
            score_inc_s = sat_add(score, PERFECT_PTS_W);
        end else if (good_s) begin
            result_s    = RES_GOOD;
            score_inc_s = sat_add(score, GOOD_PTS_W);
        end else begin
            result_s    = RES_MISS;
            score_inc_s = score;
        end
        if (!miss_s && (combo_inc_s > max_combo)) begin
            max_next_s = combo_inc_s;
        end else begin
            max_next_s = max_combo;
        end
`ifdef GHOST_PENALTY_EN
        ghost_s = !judged_s && (arrows != 4'd0);
`endif
    end

    // Chart walker FSM plus registered score/combo/judgement outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= S_IDLE;
            game_active_d_r <= 1'b0;
            note_time_r     <= 32'd0;
            note_lane_r     <= 2'd0;
            chart_addr      <= {ADDR_W{1'b0}};
            judge_valid     <= 1'b0;
            judge_result    <= 2'd0;
            judge_lane      <= 2'd0;
            score           <= {SCORE_W{1'b0}};
            combo           <= 10'd0;
            max_combo       <= 10'd0;
            chart_done      <= 1'b0;
        end else begin
            game_active_d_r <= game_active;
            judge_valid     <= 1'b0;
            if ((state_r != S_IDLE) && !game_active) begin
                // results stay visible for the game-over screen
                state_r <= S_IDLE;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        if (game_active && !game_active_d_r) begin
                            score      <= {SCORE_W{1'b0}};
                            combo      <= 10'd0;
                            max_combo  <= 10'd0;
                            chart_done <= 1'b0;
                            chart_addr <= {ADDR_W{1'b0}};
                            state_r    <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        state_r <= S_WAIT_ROM;
                    end
                    S_WAIT_ROM: begin
                        if (!chart_data[34]) begin
                            chart_done <= 1'b1;
                            state_r    <= S_DONE;
                        end else begin
                            note_time_r <= chart_data[31:0];
                            note_lane_r <= chart_data[33:32];
                            state_r     <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (!paused && judged_s) begin
                            judge_valid  <= 1'b1;
                            judge_result <= result_s;
                            judge_lane   <= note_lane_r;
                            score        <= score_inc_s;
                            combo        <= miss_s ? 10'd0 : combo_inc_s;
                            max_combo    <= max_next_s;
                            if (chart_addr == ADDR_LAST) begin
                                chart_done <= 1'b1;
                                state_r    <= S_DONE;
                            end else begin
                                chart_addr <= chart_addr + 1'b1;
                                state_r    <= S_FETCH;
                            end
`ifdef GHOST_PENALTY_EN
                        end else if (!paused && ghost_s) begin
                            judge_valid  <= 1'b1;
                            judge_result <= RES_GHOST;
                            judge_lane   <= lowest_lane(arrows);
                            combo        <= 10'd0;
`endif
                        end
                    end
                    S_DONE: begin
                        state_r <= S_DONE;
                    end
                    default: begin
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
